// File: rtl/cp0_wb_queue_pkg.sv
// Shared types and default sizes for the CP0 write-back queue.
package cp0_wb_queue_pkg;

  localparam int unsigned OITF_DEPTH   = 4;
  localparam int unsigned OITF_WIDTH   = 2;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned CP0_DATA_W   = 32;

  // Drain-barrier controller states.
  typedef enum logic [1:0] {
    CP0WB_IDLE  = 2'd0,
    CP0WB_DRAIN = 2'd1,
    CP0WB_ACK   = 2'd2
  } cp0wb_state_e;

endpackage

// File: rtl/cp0_wb_queue_ptr.sv
// Enable-increment pointer register; the extra top bit is the wrap bit.
module cp0_wb_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // Advance by one on each enabled cycle, wrapping modulo 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/cp0_wb_queue.sv
// CP0 MTC0 write-back queue with allocate/retire pulses for the
// outstanding-write tracker and an ERET/SYSCALL drain barrier.
// Optional macro CP0WB_BYPASS_EN: same-cycle pass-through when the queue is empty.
module cp0_wb_queue
  import cp0_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = OITF_DEPTH,
  parameter int unsigned PW    = OITF_WIDTH,
  parameter int unsigned AW    = REG_ADDR_W,
  parameter int unsigned DW    = CP0_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rdidx,
  input  logic [DW-1:0] in_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_rdidx,
  output logic [DW-1:0] out_wdata,
  output logic          cp0_wreg,
  output logic [AW-1:0] cp0_wreg_i_rdidx,
  output logic          cp0_wreg_wb,
  output logic [AW-1:0] cp0_wreg_wb_i_rdidx,
  input  logic          sync_req,
  output logic          sync_ack,
  output logic [PW:0]   count
);

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          wr_inc;
  logic          rd_inc;
  logic [AW-1:0] mem_idx  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  cp0wb_state_e  state;
  cp0wb_state_e  state_nxt;

  cp0_wb_ptr #(.W(PW + 1)) u_wr_ptr (.clk(clk), .rst_n(rst_n), .inc(wr_inc), .ptr(wr_ptr));
  cp0_wb_ptr #(.W(PW + 1)) u_rd_ptr (.clk(clk), .rst_n(rst_n), .inc(rd_inc), .ptr(rd_ptr));

  // Occupancy flags, handshakes and the head presentation.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    // rst_n term keeps in_ready low for the whole time reset is held.
    in_ready = rst_n & ~full & (state == CP0WB_IDLE);
    push     = in_valid & in_ready;
`ifdef CP0WB_BYPASS_EN
    bypass    = empty & in_ready & in_valid & out_ready;
    out_valid = ~empty | bypass;
    out_rdidx = bypass ? in_rdidx : mem_idx[rd_ptr[PW-1:0]];
    out_wdata = bypass ? in_wdata : mem_data[rd_ptr[PW-1:0]];
`else
    bypass    = 1'b0;
    out_valid = ~empty;
    out_rdidx = mem_idx[rd_ptr[PW-1:0]];
    out_wdata = mem_data[rd_ptr[PW-1:0]];
`endif
    pop                 = out_valid & out_ready;
    // A bypassed write is allocated and retired in one cycle without touching storage.
    wr_inc              = push & ~bypass;
    rd_inc              = pop & ~bypass;
    cp0_wreg            = push;
    cp0_wreg_i_rdidx    = in_rdidx;
    cp0_wreg_wb         = pop;
    cp0_wreg_wb_i_rdidx = out_rdidx;
    count               = wr_ptr - rd_ptr;
    sync_ack            = (state == CP0WB_ACK);
  end

  // Payload storage, written on accepted pushes only; not reset.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem_idx[wr_ptr[PW-1:0]]  <= in_rdidx;
      mem_data[wr_ptr[PW-1:0]] <= in_wdata;
    end
  end

  // Barrier state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CP0WB_IDLE;
    else        state <= state_nxt;
  end

  // Barrier next state: a started drain always runs to completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CP0WB_IDLE:  if (sync_req) state_nxt = CP0WB_DRAIN;
      CP0WB_DRAIN: if (empty)    state_nxt = CP0WB_ACK;
      CP0WB_ACK:                 state_nxt = CP0WB_IDLE;
      default:                   state_nxt = CP0WB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_wb_queue.sv
// Self-checking bench for cp0_wb_queue: queue-based reference model compared
// every cycle, plus directed sequences with literal expectations.
module tb_cp0_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rdidx;
  logic [DW-1:0] in_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_rdidx;
  logic [DW-1:0] out_wdata;
  logic          cp0_wreg;
  logic [AW-1:0] cp0_wreg_i_rdidx;
  logic          cp0_wreg_wb;
  logic [AW-1:0] cp0_wreg_wb_i_rdidx;
  logic          sync_req;
  logic          sync_ack;
  logic [PW:0]   count;

  int errors = 0;
  int checks = 0;

  cp0_wb_queue #(.DEPTH(DEPTH), .PW(PW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rdidx(in_rdidx), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdidx(out_rdidx), .out_wdata(out_wdata),
    .cp0_wreg(cp0_wreg), .cp0_wreg_i_rdidx(cp0_wreg_i_rdidx),
    .cp0_wreg_wb(cp0_wreg_wb), .cp0_wreg_wb_i_rdidx(cp0_wreg_wb_i_rdidx),
    .sync_req(sync_req), .sync_ack(sync_ack), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // mq: committed-order list of pending writes; phase: 0 normal, 1 draining, 2 acknowledging.
  entry_t mq[$];
  int     phase = 0;

  always @(negedge clk) begin
    automatic int     sz  = mq.size();
    automatic bit     byp = 1'b0;
    automatic bit     e_ir, e_ov, e_wreg, e_wb, e_ack;
    automatic entry_t head;
    if (!rst_n) begin
      mq.delete();
      phase = 0;
      sz    = 0;
    end
    e_ir = rst_n && (sz < DEPTH) && (phase == 0);
`ifdef CP0WB_BYPASS_EN
    byp = (sz == 0) && e_ir && in_valid && out_ready;
`endif
    e_ov   = (sz > 0) || byp;
    e_wreg = in_valid && e_ir;
    e_wb   = e_ov && out_ready;
    e_ack  = rst_n && (phase == 2);
    if (byp) begin
      head.idx  = in_rdidx;
      head.data = in_wdata;
    end else if (sz > 0) begin
      head = mq[0];
    end
    chk("in_ready",    int'(in_ready),    int'(e_ir));
    chk("out_valid",   int'(out_valid),   int'(e_ov));
    chk("count",       int'(count),       sz);
    chk("cp0_wreg",    int'(cp0_wreg),    int'(e_wreg));
    chk("cp0_wreg_wb", int'(cp0_wreg_wb), int'(e_wb));
    chk("sync_ack",    int'(sync_ack),    int'(e_ack));
    if (e_ov) begin
      chk("out_rdidx", int'(out_rdidx), int'(head.idx));
      chk("out_wdata", int'(out_wdata), int'(head.data));
    end
    if (e_wreg) chk("wreg_rdidx", int'(cp0_wreg_i_rdidx), int'(in_rdidx));
    if (e_wb)   chk("wb_rdidx", int'(cp0_wreg_wb_i_rdidx), int'(head.idx));
    if (rst_n) begin
      if (phase == 0 && sync_req) phase = 1;
      else if (phase == 1 && sz == 0) phase = 2;
      else if (phase == 2) phase = 0;
      if (!byp) begin
        if (e_wb) void'(mq.pop_front());
        if (e_wreg) begin
          head.idx  = in_rdidx;
          head.data = in_wdata;
          mq.push_back(head);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_empty, ack_at, acks, pulses;
    bit ack_seen;

    rst_n = 1'b0; in_valid = 1'b0; in_rdidx = '0; in_wdata = '0;
    out_ready = 1'b0; sync_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst in_ready",  int'(in_ready),  0);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst count",     int'(count),     0);
    end
    tick();
    rst_n = 1'b1;

    // 1: single push, 1-cycle latency
    in_valid = 1'b1; in_rdidx = 5'd12; in_wdata = 32'h1;
    @(negedge clk);
    chk("t1 wreg", int'(cp0_wreg), 1);
    chk("t1 wreg idx", int'(cp0_wreg_i_rdidx), 12);
    chk("t1 no bypass out_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1 out_valid", int'(out_valid), 1);
    chk("t1 out_rdidx", int'(out_rdidx), 12);
    chk("t1 out_wdata", int'(out_wdata), 1);
    chk("t1 count", int'(count), 1);
    chk("t1 wreg once", int'(cp0_wreg), 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 2: fill to full, reject fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rdidx = AW'(12 + i); in_wdata = $urandom;
      tick();
    end
    in_rdidx = 5'd16;
    @(negedge clk);
    chk("t2 count full", int'(count), 4);
    chk("t2 in_ready full", int'(in_ready), 0);
    chk("t2 fifth no wreg", int'(cp0_wreg), 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2 retire idx", int'(out_rdidx), 12 + i);
      chk("t2 retire pulse", int'(cp0_wreg_wb), 1);
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t2 drained", int'(count), 0);
    tick();

    // 3: steady stream through pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rdidx = AW'($urandom); in_wdata = $urandom;
      @(negedge clk);
      if (i > 0) chk("t3 count steady", int'(count), 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;

    // 4: drain barrier with 3 queued entries
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rdidx = AW'(20 + i); in_wdata = $urandom;
      tick();
    end
    in_valid = 1'b0; sync_req = 1'b1; out_ready = 1'b1;
    first_empty = -1; ack_at = -1; acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("t4 in_ready req cycle", int'(in_ready), 1);
      if (c == 1) chk("t4 in_ready drain", int'(in_ready), 0);
      if (count == 0 && first_empty < 0) first_empty = c;
      if (sync_ack) begin
        acks++;
        if (ack_at < 0) ack_at = c;
      end
      if (ack_at >= 0 && c == ack_at + 1) chk("t4 in_ready after ack", int'(in_ready), 1);
      tick();
      if (ack_at >= 0) sync_req = 1'b0;
    end
    sync_req = 1'b0;
    chk("t4 ack count", acks, 1);
    chk("t4 ack after empty", ack_at - first_empty, 1);
    chk("t4 ack cycle", ack_at, 4);
    out_ready = 1'b0;

    // 5: barrier on an empty queue
    sync_req = 1'b1; ack_at = -1; acks = 0; pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cp0_wreg || cp0_wreg_wb) pulses++;
      if (sync_ack) begin
        acks++;
        if (ack_at < 0) ack_at = c;
      end
      tick();
      if (ack_at >= 0) sync_req = 1'b0;
    end
    sync_req = 1'b0;
    chk("t5 ack latency", ack_at, 2);
    chk("t5 ack count", acks, 1);
    chk("t5 no pulses", pulses, 0);

`ifdef CP0WB_BYPASS_EN
    // 6a: same-cycle pass-through
    in_valid = 1'b1; out_ready = 1'b1; in_rdidx = 5'd9; in_wdata = 32'hCAFE0009;
    @(negedge clk);
    chk("t6 byp out_valid", int'(out_valid), 1);
    chk("t6 byp out_rdidx", int'(out_rdidx), 9);
    chk("t6 byp wreg", int'(cp0_wreg), 1);
    chk("t6 byp wb", int'(cp0_wreg_wb), 1);
    chk("t6 byp count", int'(count), 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6 byp count after", int'(count), 0);
    tick();
`endif

    // 6b: asynchronous reset with two entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_rdidx = AW'(3 + i); in_wdata = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6 rst count", int'(count), 0);
    chk("t6 rst out_valid", int'(out_valid), 0);
    chk("t6 rst in_ready", int'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6 no retire after rst", int'(cp0_wreg_wb), 0);
    tick();

    // Random traffic with occasional barriers.
    ack_seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 2) != 0;
      in_rdidx  = AW'($urandom);
      in_wdata  = $urandom;
      if (!sync_req && ($urandom % 50) == 0) sync_req = 1'b1;
      @(negedge clk);
      if (sync_ack) ack_seen = 1'b1;
      tick();
      if (ack_seen) begin
        sync_req = 1'b0;
        ack_seen = 1'b0;
      end
    end
    in_valid = 1'b0; sync_req = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
